// File: rtl/pspin_cfg_pkg.sv
// pspin_cfg_pkg
// Shared types for the HER traffic shaper.
//   her_descr_t : handler-execution-request descriptor handed to the scheduler
//   her_chan_t  : channel index, wide enough for the 16-channel maximum
//   gap_t       : per-descriptor inter-packet gap as stored in the channel FIFOs
//   her_req_t   : one channel FIFO entry {descriptor, gap, last-of-stream}
//   shaper_state_t : issue FSM states
package pspin_cfg_pkg;

  typedef struct packed {
    logic [15:0] msgid;
    logic [31:0] her_addr;
    logic [31:0] her_size;
  } her_descr_t;

  typedef logic [3:0] her_chan_t;

  // Stored gaps are 32 bits wide, so the shaper's GAP_WIDTH can be anything up to 32.
  typedef logic [31:0] gap_t;

  typedef struct packed {
    her_descr_t descr;
    gap_t       gap;
    logic       last;
  } her_req_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } shaper_state_t;

endpackage

// File: rtl/her_chan_fifo.sv
// her_chan_fifo
// Synchronous FIFO of her_req_t entries, one instance per producer channel.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset (empties the FIFO)
//   push_i, din_i     : write an entry (ignored when full)
//   pop_i, dout_o     : dout_o shows the head entry; pop_i removes it (ignored when empty)
//   full_o, empty_o   : occupancy flags, driven from registers only
module her_chan_fifo
  import pspin_cfg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  her_req_t din_i,
  input  logic     pop_i,
  output her_req_t dout_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  her_req_t mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign dout_o  = mem[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/her_traffic_shaper.sv
// her_traffic_shaper
// Multi-channel HER source. Each channel buffers descriptors in its own FIFO;
// a channel may issue when it has an entry, its inter-packet gap has expired
// and it has fewer than MAX_OUTSTANDING HERs unacknowledged. Eligible channels
// are round-robin arbitrated onto one HER interface, and every HER receives a
// packet-memory address from a wrapping ring pointer.
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o       : per-channel descriptor handshake
//   req_descr_i, req_gap_i, req_last_i : descriptor (her_addr ignored), gap, end-of-stream
//   her_valid_o/her_ready_i       : HER handshake to the scheduler
//   her_descr_o, her_chan_o       : issued HER (address filled in) and its channel
//   feedback_valid_i/_ready_o/_chan_i : credit return from the scheduler
//   eos_o                         : sticky, all streams ended and fully drained
//   err_o                         : sticky, feedback arrived for a channel with nothing in flight
module her_traffic_shaper
  import pspin_cfg_pkg::*;
#(
  parameter int          N_CHAN          = 4,
  parameter int          FIFO_DEPTH      = 8,
  parameter int          MAX_OUTSTANDING = 16,
  parameter int          GAP_WIDTH       = 16,
  parameter logic [31:0] PKT_MEM_START   = 32'h0000_0000,
  parameter logic [31:0] PKT_MEM_SIZE    = 32'h0040_0000,
  localparam int         CHAN_W          = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_CHAN-1:0]                req_valid_i,
  output logic [N_CHAN-1:0]                req_ready_o,
  input  her_descr_t [N_CHAN-1:0]          req_descr_i,
  input  logic [N_CHAN-1:0][GAP_WIDTH-1:0] req_gap_i,
  input  logic [N_CHAN-1:0]                req_last_i,
  output logic                             her_valid_o,
  input  logic                             her_ready_i,
  output her_descr_t                       her_descr_o,
  output logic [CHAN_W-1:0]                her_chan_o,
  input  logic                             feedback_valid_i,
  output logic                             feedback_ready_o,
  input  logic [CHAN_W-1:0]                feedback_chan_i,
  output logic                             eos_o,
  output logic                             err_o
);

  localparam int               OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE    = OUT_W'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(N_CHAN - 1);
  localparam logic [CHAN_W-1:0] CHAN_ONE  = CHAN_W'(1);
  // Ring bounds in 33 bits so ptr + size can never overflow silently.
  localparam logic [32:0] RING_START = {1'b0, PKT_MEM_START};
  localparam logic [32:0] RING_END   = RING_START + {1'b0, PKT_MEM_SIZE};

  shaper_state_t state_q, state_d;

  logic [N_CHAN-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
  her_req_t          fifo_din  [N_CHAN];
  her_req_t          fifo_dout [N_CHAN];

  logic [GAP_WIDTH-1:0] gap_cnt_q [N_CHAN];
  logic [OUT_W-1:0]     out_cnt_q [N_CHAN];
  logic [N_CHAN-1:0]    last_seen_q;
  logic                 eos_q, err_q;

  logic [CHAN_W-1:0]    rr_ptr_q, rr_next;
  logic [31:0]          ring_ptr_q, ring_ptr_d;
  logic [CHAN_W-1:0]    cur_chan_q;
  logic [GAP_WIDTH-1:0] cur_gap_q;
  logic                 cur_last_q;

  logic [N_CHAN-1:0] eligible, issue_vec, credit_vec;
  logic              pick_valid;
  logic [CHAN_W-1:0] pick_chan;
  her_req_t          head;
  her_descr_t        next_descr;
  logic              pop_any, hs;
  logic              eos_cond;
  logic              unused_head_bits;

  // Per-channel FIFOs. Ready depends only on the registered full flag, so
  // there is no combinational path from req_valid_i to req_ready_o.
  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    assign fifo_din[c]  = '{descr: req_descr_i[c], gap: gap_t'(req_gap_i[c]), last: req_last_i[c]};
    assign fifo_push[c] = req_valid_i[c] & ~fifo_full[c];

    her_chan_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (fifo_push[c]),
      .din_i  (fifo_din[c]),
      .pop_i  (fifo_pop[c]),
      .dout_o (fifo_dout[c]),
      .full_o (fifo_full[c]),
      .empty_o(fifo_empty[c])
    );
  end

  assign req_ready_o      = ~fifo_full;
  assign her_valid_o      = (state_q == ST_PRESENT);
  assign her_chan_o       = cur_chan_q;
  assign feedback_ready_o = 1'b1;
  assign eos_o            = eos_q;
  assign err_o            = err_q;

  // A channel may issue once it has data, its gap has run out and it still has credit.
  always_comb begin
    eligible = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      eligible[c] = !fifo_empty[c] && (gap_cnt_q[c] == '0) && (out_cnt_q[c] < OUT_MAX);
    end
  end

  // Round-robin: scan from rr_ptr_q upwards (wrapping) and take the first eligible channel.
  always_comb begin
    pick_valid = 1'b0;
    pick_chan  = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      int idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_CHAN) begin
        idx = idx - N_CHAN;
      end
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick_chan  = CHAN_W'(idx);
      end
    end
  end

  // Issue FSM: IDLE pops the winner into the output registers, PRESENT holds
  // them until the scheduler takes the HER.
  always_comb begin
    state_d = state_q;
    pop_any = 1'b0;
    hs      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          pop_any = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (her_ready_i) begin
          hs      = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-channel strobes: which FIFO pops, which channel completes a handshake,
  // and which channel receives a feedback credit.
  always_comb begin
    fifo_pop   = '0;
    issue_vec  = '0;
    credit_vec = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      fifo_pop[c]   = pop_any && (pick_chan == CHAN_W'(c));
      issue_vec[c]  = hs && (cur_chan_q == CHAN_W'(c));
      credit_vec[c] = feedback_valid_i && (feedback_chan_i == CHAN_W'(c));
    end
  end

  assign rr_next = (cur_chan_q == CHAN_LAST) ? '0 : cur_chan_q + CHAN_ONE;

  // Ring allocation for the head of the winning channel. A HER that would run
  // past the ring end is placed at the start instead of being split; landing
  // exactly on the end wraps the pointer back to the start.
  always_comb begin
    logic [32:0] sum;
    logic [32:0] nxt;
    head       = fifo_dout[pick_chan];
    next_descr = head.descr;
    sum        = {1'b0, ring_ptr_q} + {1'b0, head.descr.her_size};
    if (sum > RING_END) begin
      next_descr.her_addr = PKT_MEM_START;
      nxt                 = RING_START + {1'b0, head.descr.her_size};
    end else begin
      next_descr.her_addr = ring_ptr_q;
      nxt                 = sum;
    end
    if (nxt == RING_END) begin
      nxt = RING_START;
    end
    ring_ptr_d = nxt[31:0];
  end

  // The producer's her_addr is overwritten and high gap bits beyond GAP_WIDTH are dropped.
  assign unused_head_bits = ^{head.descr.her_addr, head.gap};

  // End of stream: every channel has sent its last HER, nothing is buffered,
  // nothing is being presented and every HER has been acknowledged.
  always_comb begin
    eos_cond = (&last_seen_q) && (&fifo_empty) && (state_q == ST_IDLE);
    for (int c = 0; c < N_CHAN; c++) begin
      if (out_cnt_q[c] != '0) begin
        eos_cond = 1'b0;
      end
    end
  end

  // Issue path registers: FSM state, presented HER, ring and arbitration pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      her_descr_o <= '0;
      cur_chan_q  <= '0;
      cur_gap_q   <= '0;
      cur_last_q  <= 1'b0;
      ring_ptr_q  <= PKT_MEM_START;
      rr_ptr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (pop_any) begin
        her_descr_o <= next_descr;
        cur_chan_q  <= pick_chan;
        cur_gap_q   <= head.gap[GAP_WIDTH-1:0];
        cur_last_q  <= head.last;
        ring_ptr_q  <= ring_ptr_d;
      end
      if (hs) begin
        rr_ptr_q <= rr_next;
      end
    end
  end

  // Per-channel pacing and credit state. The gap is armed at the handshake,
  // so a gap of g keeps the channel out of arbitration for g cycles. An issue
  // and a credit for the same channel in one cycle cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < N_CHAN; c++) begin
        gap_cnt_q[c] <= '0;
        out_cnt_q[c] <= '0;
      end
      last_seen_q <= '0;
      eos_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (issue_vec[c]) begin
          gap_cnt_q[c] <= cur_gap_q;
        end else if (gap_cnt_q[c] != '0) begin
          gap_cnt_q[c] <= gap_cnt_q[c] - GAP_ONE;
        end

        if (issue_vec[c] && !credit_vec[c]) begin
          out_cnt_q[c] <= out_cnt_q[c] + OUT_ONE;
        end else if (credit_vec[c] && !issue_vec[c]) begin
          if (out_cnt_q[c] == '0) begin
            err_q <= 1'b1;
          end else begin
            out_cnt_q[c] <= out_cnt_q[c] - OUT_ONE;
          end
        end

        if (issue_vec[c] && cur_last_q) begin
          last_seen_q[c] <= 1'b1;
        end
      end
      if (eos_cond) begin
        eos_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_her_traffic_shaper.sv
// tb_her_traffic_shaper
// Directed bench for her_traffic_shaper with 4 channels, MAX_OUTSTANDING=2
// and a 256-byte ring. A negedge monitor logs every HER handshake (address,
// channel, msgid, cycle); each test task drives stimulus and checks the log
// and the status outputs against hand-computed values.
module tb_her_traffic_shaper;
  import pspin_cfg_pkg::*;

  localparam int N  = 4;
  localparam int GW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  her_descr_t [N-1:0]   req_descr;
  logic [N-1:0][GW-1:0] req_gap;
  logic [N-1:0]         req_last;
  logic                 her_valid;
  logic                 her_ready;
  her_descr_t           her_descr;
  logic [1:0]           her_chan;
  logic                 fb_valid;
  logic                 fb_ready;
  logic [1:0]           fb_chan;
  logic                 eos;
  logic                 err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] hs_addr [$];
  int          hs_chan [$];
  logic [15:0] hs_msg  [$];
  int          hs_cyc  [$];

  her_traffic_shaper #(
    .N_CHAN         (N),
    .FIFO_DEPTH     (8),
    .MAX_OUTSTANDING(2),
    .GAP_WIDTH      (GW),
    .PKT_MEM_START  (32'h0),
    .PKT_MEM_SIZE   (32'd256)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_descr_i     (req_descr),
    .req_gap_i       (req_gap),
    .req_last_i      (req_last),
    .her_valid_o     (her_valid),
    .her_ready_i     (her_ready),
    .her_descr_o     (her_descr),
    .her_chan_o      (her_chan),
    .feedback_valid_i(fb_valid),
    .feedback_ready_o(fb_ready),
    .feedback_chan_i (fb_chan),
    .eos_o           (eos),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so valid&ready seen at the
  // falling edge is exactly the handshake taken at the next rising edge.
  always @(negedge clk) begin
    if (!rst && her_valid && her_ready) begin
      hs_addr.push_back(her_descr.her_addr);
      hs_chan.push_back(int'(her_chan));
      hs_msg.push_back(her_descr.msgid);
      hs_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_addr.delete();
    hs_chan.delete();
    hs_msg.delete();
    hs_cyc.delete();
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_last  = '0;
    req_gap   = '0;
    req_descr = '0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    her_ready = 1'b0;
    fb_valid  = 1'b0;
    fb_chan   = '0;
    clear_req();
    tick();
    tick();
    clear_log();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_req(input int ch, input logic [15:0] msg, input logic [31:0] size,
                         input logic [GW-1:0] gap, input logic last);
    req_valid[ch]          = 1'b1;
    req_descr[ch].msgid    = msg;
    req_descr[ch].her_addr = 32'hDEAD_BEEF;
    req_descr[ch].her_size = size;
    req_gap[ch]            = gap;
    req_last[ch]           = last;
  endtask

  task automatic give_fb(input int ch);
    fb_valid = 1'b1;
    fb_chan  = 2'(ch);
    tick();
    fb_valid = 1'b0;
  endtask

  task automatic wait_hs(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (hs_addr.size() < n && k < budget) begin
      tick();
      k++;
    end
    tests++;
    if (hs_addr.size() < n) begin
      fails++;
      $display("FAIL %s: got %0d handshakes, expected %0d", name, hs_addr.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (her_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", her_valid); end
    tests++; if (her_descr !== '0) begin fails++; $display("FAIL reset_descr: got %h expected 0", her_descr); end
    tests++; if (her_chan !== 2'd0) begin fails++; $display("FAIL reset_chan: got %0d expected 0", her_chan); end
    tests++; if (eos !== 1'b0) begin fails++; $display("FAIL reset_eos: got %b expected 0", eos); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    tests++; if (req_ready !== 4'hF) begin fails++; $display("FAIL reset_ready: got %b expected 1111", req_ready); end
    tests++; if (fb_ready !== 1'b1) begin fails++; $display("FAIL reset_fb_ready: got %b expected 1", fb_ready); end
  endtask

  // Three 64-byte HERs on channel 0: two issue, the third waits for a credit.
  task automatic test_single_chan();
    do_reset();
    her_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 16'(i + 1), 32'd64, '0, 1'b0);
      tick();
    end
    clear_req();
    wait_hs(2, 20, "single_first_two");
    repeat (10) tick();
    tests++; if (hs_addr.size() != 2) begin fails++; $display("FAIL single_credit_limit: got %0d handshakes expected 2", hs_addr.size()); end
    if (hs_addr.size() >= 2) begin
      tests++; if (hs_addr[0] !== 32'h0) begin fails++; $display("FAIL single_addr0: got %h expected 0", hs_addr[0]); end
      tests++; if (hs_addr[1] !== 32'h40) begin fails++; $display("FAIL single_addr1: got %h expected 40", hs_addr[1]); end
      tests++; if (hs_cyc[1] - hs_cyc[0] != 2) begin fails++; $display("FAIL single_spacing: got %0d expected 2", hs_cyc[1] - hs_cyc[0]); end
      tests++; if (hs_chan[1] != 0) begin fails++; $display("FAIL single_chan: got %0d expected 0", hs_chan[1]); end
    end
    give_fb(0);
    wait_hs(3, 20, "single_after_credit");
    if (hs_addr.size() >= 3) begin
      tests++; if (hs_addr[2] !== 32'h80) begin fails++; $display("FAIL single_addr2: got %h expected 80", hs_addr[2]); end
      tests++; if (hs_msg[2] !== 16'd3) begin fails++; $display("FAIL single_msgid2: got %0d expected 3", hs_msg[2]); end
    end
  endtask

  // Two entries per channel pushed in parallel: strict 0,1,2,3,0,1,2,3 rotation.
  task automatic test_round_robin();
    do_reset();
    her_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < N; c++) set_req(c, 16'(r * 16 + c), 32'd16, '0, 1'b0);
      tick();
    end
    clear_req();
    wait_hs(8, 60, "rr_count");
    for (int i = 0; i < 8 && i < hs_chan.size(); i++) begin
      tests++;
      if (hs_chan[i] != i % N) begin
        fails++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", i, hs_chan[i], i % N);
      end
    end
  endtask

  // Channel 0 carries gap 10; channel 1 traffic is issued while channel 0 waits.
  task automatic test_gap();
    do_reset();
    her_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      set_req(0, 16'(r), 32'd8, 16'd10, 1'b0);
      set_req(1, 16'(r + 8), 32'd8, 16'd0, 1'b0);
      tick();
    end
    clear_req();
    wait_hs(4, 80, "gap_count");
    if (hs_chan.size() >= 4) begin
      tests++; if (hs_chan[0] != 0) begin fails++; $display("FAIL gap_order0: got %0d expected 0", hs_chan[0]); end
      tests++; if (hs_chan[1] != 1) begin fails++; $display("FAIL gap_order1: got %0d expected 1", hs_chan[1]); end
      tests++; if (hs_chan[2] != 1) begin fails++; $display("FAIL gap_order2: got %0d expected 1", hs_chan[2]); end
      tests++; if (hs_chan[3] != 0) begin fails++; $display("FAIL gap_order3: got %0d expected 0", hs_chan[3]); end
      tests++; if (hs_cyc[3] - hs_cyc[0] < 11) begin fails++; $display("FAIL gap_spacing: got %0d cycles expected at least 11", hs_cyc[3] - hs_cyc[0]); end
    end
  endtask

  // 256-byte ring: 200 then 100 wraps to 0 and leaves the pointer at 100.
  task automatic test_wrap();
    do_reset();
    her_ready = 1'b1;
    set_req(0, 16'd1, 32'd200, '0, 1'b0);
    tick();
    set_req(0, 16'd2, 32'd100, '0, 1'b0);
    tick();
    clear_req();
    wait_hs(2, 20, "wrap_first_two");
    give_fb(0);
    set_req(0, 16'd3, 32'd16, '0, 1'b0);
    tick();
    clear_req();
    wait_hs(3, 20, "wrap_third");
    if (hs_addr.size() >= 3) begin
      tests++; if (hs_addr[0] !== 32'd0) begin fails++; $display("FAIL wrap_addr0: got %0d expected 0", hs_addr[0]); end
      tests++; if (hs_addr[1] !== 32'd0) begin fails++; $display("FAIL wrap_addr1: got %0d expected 0", hs_addr[1]); end
      tests++; if (hs_addr[2] !== 32'd100) begin fails++; $display("FAIL wrap_ptr_after: got %0d expected 100", hs_addr[2]); end
    end
  endtask

  // Back-pressure hold, reset in the middle of the hold, then a stray credit.
  task automatic test_hold_reset_err();
    her_descr_t exp;
    int k;
    do_reset();
    set_req(2, 16'h55, 32'd32, '0, 1'b0);
    tick();
    set_req(2, 16'h56, 32'd32, '0, 1'b0);
    tick();
    clear_req();
    k = 0;
    while (!her_valid && k < 10) begin tick(); k++; end
    tests++; if (her_valid !== 1'b1) begin fails++; $display("FAIL hold_valid_rise: got %b expected 1", her_valid); end
    exp = '0;
    exp.msgid    = 16'h55;
    exp.her_addr = 32'h0;
    exp.her_size = 32'd32;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (her_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, her_valid); end
      tests++; if (her_descr !== exp) begin fails++; $display("FAIL hold_descr[%0d]: got %h expected %h", i, her_descr, exp); end
      tests++; if (her_chan !== 2'd2) begin fails++; $display("FAIL hold_chan[%0d]: got %0d expected 2", i, her_chan); end
    end
    rst = 1'b1;
    #2;
    tests++; if (her_valid !== 1'b0) begin fails++; $display("FAIL reset_mid_hold_valid: got %b expected 0", her_valid); end
    tests++; if (req_ready !== 4'hF) begin fails++; $display("FAIL reset_mid_hold_ready: got %b expected 1111", req_ready); end
    tick();
    clear_log();
    rst       = 1'b0;
    her_ready = 1'b1;
    repeat (6) tick();
    tests++; if (hs_addr.size() != 0) begin fails++; $display("FAIL reset_flush: got %0d handshakes expected 0", hs_addr.size()); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_before: got %b expected 0", err); end
    give_fb(1);
    tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_set: got %b expected 1", err); end
    repeat (3) tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  // One last-marked zero-size HER per channel; eos_o only after every credit returns.
  task automatic test_eos();
    do_reset();
    her_ready = 1'b1;
    for (int c = 0; c < N; c++) set_req(c, 16'(c), 32'd0, '0, 1'b1);
    tick();
    clear_req();
    wait_hs(4, 40, "eos_issue");
    repeat (2) tick();
    tests++; if (eos !== 1'b0) begin fails++; $display("FAIL eos_outstanding: got %b expected 0", eos); end
    if (hs_addr.size() >= 4) begin
      tests++; if (hs_addr[3] !== 32'd0) begin fails++; $display("FAIL eos_zero_size_addr: got %0d expected 0", hs_addr[3]); end
    end
    give_fb(0);
    give_fb(1);
    give_fb(2);
    repeat (2) tick();
    tests++; if (eos !== 1'b0) begin fails++; $display("FAIL eos_three_credits: got %b expected 0", eos); end
    give_fb(3);
    repeat (2) tick();
    tests++; if (eos !== 1'b1) begin fails++; $display("FAIL eos_rise: got %b expected 1", eos); end
    set_req(0, 16'h77, 32'd8, '0, 1'b0);
    tick();
    clear_req();
    wait_hs(5, 20, "eos_late_push");
    if (hs_chan.size() >= 5) begin
      tests++; if (hs_msg[4] !== 16'h77) begin fails++; $display("FAIL eos_late_msgid: got %h expected 77", hs_msg[4]); end
    end
    repeat (2) tick();
    tests++; if (eos !== 1'b1) begin fails++; $display("FAIL eos_sticky: got %b expected 1", eos); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL eos_no_err: got %b expected 0", err); end
  endtask

  initial begin
    rst       = 1'b1;
    her_ready = 1'b0;
    fb_valid  = 1'b0;
    fb_chan   = '0;
    clear_req();
    test_reset();
    test_single_chan();
    test_round_robin();
    test_gap();
    test_wrap();
    test_hold_reset_err();
    test_eos();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
